psum_accumulator: RTL and testbench

//   Downstream stage of the MAC array. Sums per-MAC 5-bit partial sums over a programmable

---
 rtl/psum_accumulator.sv | 166 ++++++++++++++++
 tb/tb_psum_accumulator.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//
// Purpose:
//    Downstream stage of the MAC array. Each of MAC_NUM lanes sums its 5-bit
//    partial sums over a programmable number of input-channel passes. The sum
//    saturates instead of wrapping. When the job finishes, every lane sum is
//    compared against a threshold to produce one output activation bit. The
//    packed result is held with a valid/ready handshake until the output
//    buffer takes it.
//
// Ports:
//    i_clk           clock, all logic on the rising edge
//    i_rst           synchronous reset, active-high
//    i_start         one-cycle pulse that starts a job (honoured only in IDLE)
//    i_numChannels   number of psum beats in the job, sampled on accepted start
//    i_threshold     binarization threshold, sampled on accepted start
//    i_psumIn        packed lane partial sums, lane i at [i*PSUM_W +: PSUM_W]
//    i_psumValid     i_psumIn carries a valid beat
//    o_psumReady     stage accepts a beat this cycle (ACCUM state)
//    o_accOut        packed raw lane sums, lane i at [i*ACC_W +: ACC_W]
//    o_actOut        bit i = (lane i sum >= latched threshold)
//    o_outValid      o_accOut/o_actOut hold a finished job (HOLD state)
//    i_outReady      consumer accepts the result
//    o_busy          high while in ACCUM or HOLD
// ---------------------------------------------------------------------------
module psum_accumulator #(
    parameter int MAC_NUM  = 256,
    parameter int PSUM_W   = 5,
    parameter int ACC_W    = 13,
    parameter int CH_CNT_W = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [CH_CNT_W-1:0]         i_numChannels,
    input  logic [ACC_W-1:0]            i_threshold,
    input  logic [PSUM_W*MAC_NUM-1:0]   i_psumIn,
    input  logic                        i_psumValid,
    output logic                        o_psumReady,
    output logic [ACC_W*MAC_NUM-1:0]    o_accOut,
    output logic [MAC_NUM-1:0]          o_actOut,
    output logic                        o_outValid,
    input  logic                        i_outReady,
    output logic                        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stateT;

    localparam logic [CH_CNT_W-1:0] CNT_ONE = CH_CNT_W'(1);

    stateT                     r_state;
    stateT                     w_stateNext;
    logic [CH_CNT_W-1:0]       r_beatCnt;
    logic [CH_CNT_W-1:0]       r_numChannels;
    logic [ACC_W-1:0]          r_threshold;
    logic [ACC_W*MAC_NUM-1:0]  r_acc;
    logic [MAC_NUM-1:0]        r_act;
    logic [ACC_W*MAC_NUM-1:0]  w_accNext;
    logic [MAC_NUM-1:0]        w_actNext;
    logic                      w_startAccept;
    logic                      w_beatAccept;
    logic                      w_lastBeat;

    // One lane add: the extra carry bit detects overflow, in which case the
    // lane pins at all ones rather than wrapping back towards zero.
    function automatic logic [ACC_W-1:0] satAdd(
        input logic [ACC_W-1:0]  acc,
        input logic [PSUM_W-1:0] psum
    );
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(psum);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    // A start only counts in IDLE and with a non-zero channel count; anything
    // else (zero count, start while busy, start during the HOLD handshake) is
    // dropped here so the rest of the logic never sees it.
    assign w_startAccept = (r_state == IDLE) && i_start && (i_numChannels != '0);
    assign w_beatAccept  = (r_state == ACCUM) && i_psumValid;
    assign w_lastBeat    = w_beatAccept && (r_beatCnt == (r_numChannels - CNT_ONE));

    // State register; reset always wins so an aborted job never reaches HOLD.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: IDLE waits for an accepted start, ACCUM waits for the
    // final beat, HOLD waits for the consumer to take the result.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_startAccept) begin
                    w_stateNext = ACCUM;
                end
            end
            ACCUM: begin
                if (w_lastBeat) begin
                    w_stateNext = HOLD;
                end
            end
            HOLD: begin
                if (i_outReady) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Per-lane next sums and threshold compares. The compare is taken on the
    // post-add value so that the activation bits are already correct in the
    // same cycle the last beat's sum appears on o_accOut.
    always_comb begin
        w_accNext = r_acc;
        w_actNext = r_act;
        for (int i = 0; i < MAC_NUM; i++) begin
            w_accNext[i*ACC_W +: ACC_W] = satAdd(r_acc[i*ACC_W +: ACC_W],
                                                 i_psumIn[i*PSUM_W +: PSUM_W]);
            w_actNext[i] = (w_accNext[i*ACC_W +: ACC_W] >= r_threshold);
        end
    end

    // Datapath registers. An accepted start latches the job parameters and
    // clears the previous result; an accepted beat folds in one psum per lane.
    // Outside those events the result is simply held, which keeps it stable
    // through HOLD and after the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc         <= '0;
            r_act         <= '0;
            r_beatCnt     <= '0;
            r_numChannels <= '0;
            r_threshold   <= '0;
        end else if (w_startAccept) begin
            r_acc         <= '0;
            r_act         <= '0;
            r_beatCnt     <= '0;
            r_numChannels <= i_numChannels;
            r_threshold   <= i_threshold;
        end else if (w_beatAccept) begin
            r_acc         <= w_accNext;
            r_act         <= w_actNext;
            r_beatCnt     <= r_beatCnt + CNT_ONE;
        end
    end

    // Handshake and status flags come straight from the state register.
    assign o_psumReady = (r_state == ACCUM);
    assign o_outValid  = (r_state == HOLD);
    assign o_busy      = (r_state != IDLE);
    assign o_accOut    = r_acc;
    assign o_actOut    = r_act;

endmodule

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator
//
// Directed bench for psum_accumulator. Two instances share one stimulus
// stream: the default 13-bit accumulator and an 8-bit variant used to show
// saturation. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_psum_accumulator;

    localparam int MAC_NUM  = 256;
    localparam int PSUM_W   = 5;
    localparam int ACC_W    = 13;
    localparam int ACC8_W   = 8;
    localparam int CH_CNT_W = 8;

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic [CH_CNT_W-1:0]        numChannels;
    logic [ACC_W-1:0]           thr13;
    logic [ACC8_W-1:0]          thr8;
    logic [PSUM_W*MAC_NUM-1:0]  psumIn;
    logic                       psumValid;
    logic                       outReady;

    logic                       psumReady13;
    logic [ACC_W*MAC_NUM-1:0]   acc13;
    logic [MAC_NUM-1:0]         act13;
    logic                       outValid13;
    logic                       busy13;

    logic                       psumReady8;
    logic [ACC8_W*MAC_NUM-1:0]  acc8;
    logic [MAC_NUM-1:0]         act8;
    logic                       outValid8;
    logic                       busy8;

    int total;
    int bad;

    psum_accumulator #(
        .MAC_NUM(MAC_NUM), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .CH_CNT_W(CH_CNT_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_numChannels(numChannels), .i_threshold(thr13),
        .i_psumIn(psumIn), .i_psumValid(psumValid),
        .o_psumReady(psumReady13), .o_accOut(acc13), .o_actOut(act13),
        .o_outValid(outValid13), .i_outReady(outReady), .o_busy(busy13)
    );

    psum_accumulator #(
        .MAC_NUM(MAC_NUM), .PSUM_W(PSUM_W), .ACC_W(ACC8_W), .CH_CNT_W(CH_CNT_W)
    ) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_numChannels(numChannels), .i_threshold(thr8),
        .i_psumIn(psumIn), .i_psumValid(psumValid),
        .o_psumReady(psumReady8), .o_accOut(acc8), .o_actOut(act8),
        .o_outValid(outValid8), .i_outReady(outReady), .o_busy(busy8)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the DUT ever wedges the stimulus sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drives the control inputs for one cycle and advances to the next
    // falling edge, where the effect of that cycle can be observed.
    task automatic applyStimulus(input logic st, input logic [CH_CNT_W-1:0] nc,
                                 input logic [ACC_W-1:0] thr, input logic pv,
                                 input logic ordy);
        start       = st;
        numChannels = nc;
        thr13       = thr;
        thr8        = (thr > 13'd255) ? 8'd255 : thr[ACC8_W-1:0];
        psumValid   = pv;
        outReady    = ordy;
        @(negedge clk);
    endtask

    task automatic setLanes(input logic [PSUM_W-1:0] v);
        for (int i = 0; i < MAC_NUM; i++) begin
            psumIn[i*PSUM_W +: PSUM_W] = v;
        end
    endtask

    function automatic logic [31:0] lane13(input int i);
        return 32'(acc13[i*ACC_W +: ACC_W]);
    endfunction

    function automatic logic [31:0] lane8(input int i);
        return 32'(acc8[i*ACC8_W +: ACC8_W]);
    endfunction

    function automatic logic [31:0] allLanes13(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAC_NUM; i++) begin
            if (lane13(i) != v) ok = 1'b0;
        end
        return 32'(ok);
    endfunction

    function automatic logic [31:0] allLanes8(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAC_NUM; i++) begin
            if (lane8(i) != v) ok = 1'b0;
        end
        return 32'(ok);
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // T1: reset with random junk on every input.
        rst = 1'b1;
        for (int i = 0; i < MAC_NUM; i++) begin
            psumIn[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom_range(0, 25));
        end
        start       = 1'b1;
        numChannels = CH_CNT_W'($urandom_range(1, 255));
        thr13       = ACC_W'($urandom);
        thr8        = ACC8_W'($urandom);
        psumValid   = 1'b1;
        outReady    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("T1 psumReady", 32'(psumReady13), 0);
        checkOutput("T1 outValid", 32'(outValid13), 0);
        checkOutput("T1 busy", 32'(busy13), 0);
        checkOutput("T1 accZero", 32'(acc13 == '0), 1);
        checkOutput("T1 actZero", 32'(act13 == '0), 1);
        rst = 1'b0;
        setLanes(0);
        applyStimulus(0, 0, 0, 0, 0);

        // T2: basic 3-beat job, 10+20+15 = 45 >= 40 in every lane.
        $display("[TB] T2 basic job");
        applyStimulus(1, 3, 40, 0, 0);
        checkOutput("T2 psumReady", 32'(psumReady13), 1);
        checkOutput("T2 busy", 32'(busy13), 1);
        setLanes(10);
        applyStimulus(0, 3, 40, 1, 0);
        setLanes(20);
        applyStimulus(0, 3, 40, 1, 0);
        checkOutput("T2 notYetValid", 32'(outValid13), 0);
        setLanes(15);
        applyStimulus(0, 3, 40, 1, 0);
        checkOutput("T2 outValid", 32'(outValid13), 1);
        checkOutput("T2 lane0", lane13(0), 45);
        checkOutput("T2 allLanes45", allLanes13(45), 1);
        checkOutput("T2 actAllOnes", 32'(&act13), 1);
        checkOutput("T2 acc8Lanes45", allLanes8(45), 1);
        applyStimulus(0, 3, 40, 0, 1);
        checkOutput("T2 idleValid", 32'(outValid13), 0);
        checkOutput("T2 idleBusy", 32'(busy13), 0);
        checkOutput("T2 accKept", lane13(7), 45);

        // T3: per-lane threshold edge at 25.
        $display("[TB] T3 threshold edge");
        applyStimulus(1, 1, 25, 0, 0);
        setLanes(0);
        psumIn[0*PSUM_W +: PSUM_W] = 5'd25;
        psumIn[1*PSUM_W +: PSUM_W] = 5'd24;
        applyStimulus(0, 1, 25, 1, 0);
        checkOutput("T3 outValid", 32'(outValid13), 1);
        checkOutput("T3 lane0", lane13(0), 25);
        checkOutput("T3 lane1", lane13(1), 24);
        checkOutput("T3 act0", 32'(act13[0]), 1);
        checkOutput("T3 act1", 32'(act13[1]), 0);
        checkOutput("T3 act255", 32'(act13[255]), 0);
        checkOutput("T3 act8_0", 32'(act8[0]), 1);
        applyStimulus(0, 1, 25, 0, 1);

        // T4: valid gaps then backpressure; only 5+7+9+11 = 32 counts.
        $display("[TB] T4 gaps and backpressure");
        applyStimulus(1, 4, 30, 0, 0);
        setLanes(5);
        applyStimulus(0, 4, 30, 1, 0);
        setLanes(25);
        applyStimulus(0, 4, 30, 0, 0);
        setLanes(7);
        applyStimulus(0, 4, 30, 1, 0);
        setLanes(25);
        applyStimulus(0, 4, 30, 0, 0);
        setLanes(9);
        applyStimulus(0, 4, 30, 1, 0);
        checkOutput("T4 stillAccum", 32'(psumReady13), 1);
        checkOutput("T4 notYetValid", 32'(outValid13), 0);
        setLanes(11);
        applyStimulus(0, 4, 30, 1, 0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("T4 holdValid", 32'(outValid13), 1);
            checkOutput("T4 holdReady", 32'(psumReady13), 0);
            checkOutput("T4 lane0", lane13(0), 32);
            checkOutput("T4 lane255", lane13(255), 32);
            checkOutput("T4 act0", 32'(act13[0]), 1);
            setLanes(25);
            applyStimulus(0, 4, 30, 1, 0);
        end
        checkOutput("T4 holdValidEnd", 32'(outValid13), 1);
        applyStimulus(0, 4, 30, 0, 1);
        checkOutput("T4 released", 32'(busy13), 0);

        // T5: 255 beats of 25: 6375 in 13 bits, saturates to 255 in 8 bits.
        $display("[TB] T5 saturation");
        applyStimulus(1, 255, 6375, 0, 0);
        setLanes(25);
        for (int b = 0; b < 255; b++) begin
            if (b == 254) begin
                checkOutput("T5 notYetValid", 32'(outValid13), 0);
            end
            applyStimulus(0, 255, 6375, 1, 0);
        end
        checkOutput("T5 outValid", 32'(outValid13), 1);
        checkOutput("T5 lane0", lane13(0), 6375);
        checkOutput("T5 allLanes6375", allLanes13(6375), 1);
        checkOutput("T5 actEqual", 32'(&act13), 1);
        checkOutput("T5 outValid8", 32'(outValid8), 1);
        checkOutput("T5 sat8Lane0", lane8(0), 255);
        checkOutput("T5 sat8AllLanes", allLanes8(255), 1);
        checkOutput("T5 act8AllOnes", 32'(&act8), 1);
        applyStimulus(0, 255, 6375, 0, 1);

        // T6a: start with zero channels is dropped.
        $display("[TB] T6 corner events");
        applyStimulus(1, 0, 5, 0, 0);
        checkOutput("T6 zeroChBusy", 32'(busy13), 0);
        checkOutput("T6 zeroChReady", 32'(psumReady13), 0);

        // T6b: start during ACCUM and during the HOLD handshake are dropped.
        applyStimulus(1, 2, 7, 0, 0);
        setLanes(3);
        applyStimulus(1, 5, 0, 1, 0);
        checkOutput("T6 midStartAcc", lane13(0), 3);
        checkOutput("T6 midStartValid", 32'(outValid13), 0);
        setLanes(4);
        applyStimulus(0, 5, 0, 1, 0);
        checkOutput("T6 midStartDone", 32'(outValid13), 1);
        checkOutput("T6 midStartSum", lane13(0), 7);
        checkOutput("T6 midStartAct", 32'(act13[0]), 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("T6 hsStartBusy", 32'(busy13), 0);
        checkOutput("T6 hsStartAcc", lane13(0), 7);

        // T6c: reset after 2 of 4 beats aborts the job.
        applyStimulus(1, 4, 0, 0, 0);
        setLanes(6);
        applyStimulus(0, 4, 0, 1, 0);
        applyStimulus(0, 4, 0, 1, 0);
        checkOutput("T6 partialSum", lane13(0), 12);
        rst = 1'b1;
        applyStimulus(0, 4, 0, 1, 0);
        rst = 1'b0;
        checkOutput("T6 rstBusy", 32'(busy13), 0);
        checkOutput("T6 rstValid", 32'(outValid13), 0);
        checkOutput("T6 rstAccZero", 32'(acc13 == '0), 1);
        applyStimulus(0, 4, 0, 1, 0);
        applyStimulus(0, 4, 0, 1, 0);
        checkOutput("T6 noLateValid", 32'(outValid13), 0);
        checkOutput("T6 idleNoAcc", lane13(0), 0);
        applyStimulus(1, 1, 9, 0, 0);
        setLanes(9);
        applyStimulus(0, 1, 9, 1, 0);
        checkOutput("T6 afterRstValid", 32'(outValid13), 1);
        checkOutput("T6 afterRstSum", lane13(0), 9);
        checkOutput("T6 afterRstAct", 32'(act13[0]), 1);
        applyStimulus(0, 1, 9, 0, 1);
        checkOutput("T6 finalIdle", 32'(busy13), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
